// File: rtl/hhmm_generation_ctrl.sv
// Generation sequencer for the HHMM evolutionary training loop:
// datapath reset, evaluation frame, winner scan and offload streaming.
module hhmm_generation_ctrl #(
   parameter int NC          = 4,
   parameter int INIT_CYCLES = 5,
   parameter int OFFLOAD_LEN = 11,
   localparam int CW         = (NC > 2) ? $clog2(NC) : 1
) (
   input  logic          CLK,
   input  logic          RESET_n,
   input  logic          start,
   input  logic          abort,
   input  logic [15:0]   frame_duration,
   input  logic [15:0]   gen_limit,
   input  logic [7:0]    fit_upper,
   input  logic [7:0]    fit_lower,
   input  logic          off_ready,
   output logic          dp_reset,
   output logic          frame_active,
   output logic          frame_done,
   output logic [CW-1:0] cand_sel,
   output logic [NC-1:0] keep_mut,
   output logic [15:0]   best_fit,
   output logic          off_valid,
   output logic [7:0]    off_index,
   output logic [15:0]   gen_count,
   output logic          busy
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] INIT    = 3'd1;
   localparam logic [2:0] RUN     = 3'd2;
   localparam logic [2:0] EVAL    = 3'd3;
   localparam logic [2:0] OFFLOAD = 3'd4;

   localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
   localparam logic [15:0] EVAL_LAST = 16'(2 * NC - 1);
   localparam logic [7:0]  OFF_LAST  = 8'(OFFLOAD_LEN - 1);
   localparam logic [NC-1:0] ONE     = NC'(1);

   logic [2:0]    state;
   logic [15:0]   cnt;
   logic [15:0]   dur;
   logic [15:0]   lim;
   logic [15:0]   win_fit;
   logic [CW-1:0] win_idx;
   logic          first_gen;

   logic [15:0]   fit;
   logic          take;
   logic [15:0]   fin_fit;
   logic [CW-1:0] fin_idx;
   logic [15:0]   gen_next;

   // Running winner including the candidate sampled this cycle;
   // the first sample of a scan always seeds it, ties keep the lower index.
   always_comb begin
      fit      = {fit_upper, fit_lower};
      take     = (cnt == 16'd1) || (fit > win_fit);
      fin_fit  = take ? fit : win_fit;
      fin_idx  = take ? cand_sel : win_idx;
      gen_next = (gen_count == 16'hFFFF) ? gen_count : gen_count + 16'd1;
   end

   // Phase sequencer; every output is registered alongside the state.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state        <= IDLE;
         cnt          <= '0;
         dur          <= '0;
         lim          <= '0;
         win_fit      <= '0;
         win_idx      <= '0;
         first_gen    <= 1'b1;
         dp_reset     <= 1'b1;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
         cand_sel     <= '0;
         keep_mut     <= '0;
         best_fit     <= '0;
         off_valid    <= 1'b0;
         off_index    <= '0;
         gen_count    <= '0;
         busy         <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state != IDLE && abort) begin
            state        <= IDLE;
            dp_reset     <= 1'b1;
            frame_active <= 1'b0;
            off_valid    <= 1'b0;
            cand_sel     <= '0;
            busy         <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     lim       <= gen_limit;
                     gen_count <= '0;
                     best_fit  <= '0;
                     keep_mut  <= '0;
                     first_gen <= 1'b1;
                     cnt       <= '0;
                     busy      <= 1'b1;
                     state     <= INIT;
                  end
               end
               INIT: begin
                  if (cnt == INIT_LAST) begin
                     dur          <= (frame_duration == 16'd0) ? 16'd1 : frame_duration;
                     cnt          <= 16'd1;
                     dp_reset     <= 1'b0;
                     frame_active <= 1'b1;
                     state        <= RUN;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               RUN: begin
                  if (cnt == dur) begin
                     cnt          <= '0;
                     frame_active <= 1'b0;
                     frame_done   <= 1'b1;
                     cand_sel     <= '0;
                     state        <= EVAL;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
               EVAL: begin
                  if (cnt[0]) begin
                     win_fit <= fin_fit;
                     win_idx <= fin_idx;
                  end
                  if (cnt == EVAL_LAST) begin
                     if (first_gen || fin_fit > best_fit) begin
                        best_fit  <= fin_fit;
                        keep_mut  <= ONE << fin_idx;
                        first_gen <= 1'b0;
                     end else begin
                        keep_mut <= '0;
                     end
                     cand_sel  <= '0;
                     off_valid <= 1'b1;
                     off_index <= '0;
                     state     <= OFFLOAD;
                  end else begin
                     cnt      <= cnt + 16'd1;
                     cand_sel <= CW'((cnt + 16'd1) >> 1);
                  end
               end
               OFFLOAD: begin
                  if (off_ready) begin
                     if (off_index == OFF_LAST) begin
                        off_valid <= 1'b0;
                        gen_count <= gen_next;
                        dp_reset  <= 1'b1;
                        cnt       <= '0;
                        if (lim != 16'd0 && gen_next == lim) begin
                           busy  <= 1'b0;
                           state <= IDLE;
                        end else begin
                           state <= INIT;
                        end
                     end else begin
                        off_index <= off_index + 8'd1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hhmm_generation_ctrl.sv
// Self-checking bench for hhmm_generation_ctrl: sequential reference
// model of one generation, per-cycle compare process, literal pins.
module tb_hhmm_generation_ctrl;

   localparam int NC   = 4;
   localparam int INIT = 5;
   localparam int OFF  = 11;

   logic        CLK = 1'b0;
   logic        RESET_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] frame_duration = '0;
   logic [15:0] gen_limit = '0;
   logic [7:0]  fit_upper = '0;
   logic [7:0]  fit_lower = '0;
   logic        off_ready = 1'b1;
   logic        dp_reset;
   logic        frame_active;
   logic        frame_done;
   logic [1:0]  cand_sel;
   logic [3:0]  keep_mut;
   logic [15:0] best_fit;
   logic        off_valid;
   logic [7:0]  off_index;
   logic [15:0] gen_count;
   logic        busy;

   hhmm_generation_ctrl #(
      .NC(NC), .INIT_CYCLES(INIT), .OFFLOAD_LEN(OFF)
   ) dut (
      .CLK(CLK), .RESET_n(RESET_n), .start(start), .abort(abort),
      .frame_duration(frame_duration), .gen_limit(gen_limit),
      .fit_upper(fit_upper), .fit_lower(fit_lower),
      .off_ready(off_ready), .dp_reset(dp_reset),
      .frame_active(frame_active), .frame_done(frame_done),
      .cand_sel(cand_sel), .keep_mut(keep_mut), .best_fit(best_fit),
      .off_valid(off_valid), .off_index(off_index),
      .gen_count(gen_count), .busy(busy)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;
   bit chk = 0;

   logic        e_dp, e_fa, e_fd, e_ov, e_busy;
   logic [1:0]  e_cs;
   logic [3:0]  e_keep;
   logic [15:0] e_best, e_gc;
   logic [7:0]  e_idx;

   logic [15:0] m_best, m_gc, m_lim;
   logic [3:0]  m_keep;
   bit          m_first;

   int busy_cnt = 0, fa_cnt = 0, fd_cnt = 0, xfer_cnt = 0;

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare every output against the model on the falling edge.
   always @(negedge CLK) begin
      if (chk) begin
         check("dp_reset", 16'(dp_reset), 16'(e_dp));
         check("frame_active", 16'(frame_active), 16'(e_fa));
         check("frame_done", 16'(frame_done), 16'(e_fd));
         check("cand_sel", 16'(cand_sel), 16'(e_cs));
         check("keep_mut", 16'(keep_mut), 16'(e_keep));
         check("best_fit", best_fit, e_best);
         check("off_valid", 16'(off_valid), 16'(e_ov));
         check("gen_count", gen_count, e_gc);
         check("busy", 16'(busy), 16'(e_busy));
         if (e_ov) check("off_index", 16'(off_index), 16'(e_idx));
      end
      if (busy) busy_cnt++;
      if (frame_active) fa_cnt++;
      if (frame_done) fd_cnt++;
      if (off_valid && off_ready) xfer_cnt++;
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_exp();
      e_dp = 1; e_fa = 0; e_fd = 0; e_cs = 0; e_ov = 0; e_busy = 0;
      e_gc = m_gc; e_best = m_best; e_keep = m_keep;
   endtask

   task automatic do_start(input logic [15:0] lim);
      start = 1; gen_limit = lim; m_lim = lim;
      cyc();
      start = 0; gen_limit = 16'h00AA;
      m_gc = 0; m_best = 0; m_keep = 0; m_first = 1;
   endtask

   // One generation as the sequence of phases it must produce.
   task automatic gen(input logic [15:0] dur,
                      input logic [15:0] f0, input logic [15:0] f1,
                      input logic [15:0] f2, input logic [15:0] f3,
                      input int rmode, input int abort_at, input int rst_at);
      logic [15:0] f [4];
      int d, wi, beats, k;
      f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
      for (int i = 0; i < INIT; i++) begin
         e_dp = 1; e_busy = 1; e_fa = 0; e_fd = 0; e_cs = 0; e_ov = 0;
         e_gc = m_gc; e_best = m_best; e_keep = m_keep;
         frame_duration = dur;
         cyc();
      end
      frame_duration = 16'hFFFF;
      d = (dur == 0) ? 1 : int'(dur);
      for (int i = 0; i < d; i++) begin
         e_dp = 0; e_fa = 1;
         if (i == abort_at) begin
            abort = 1;
            cyc();
            abort = 0;
            idle_exp();
            return;
         end
         cyc();
      end
      for (int j = 0; j < 2 * NC; j++) begin
         e_fa = 0; e_fd = (j == 0); e_cs = 2'(j / 2);
         fit_upper = f[j/2][15:8]; fit_lower = f[j/2][7:0];
         cyc();
      end
      wi = 0;
      for (int c = 1; c < NC; c++) if (f[c] > f[wi]) wi = c;
      if (m_first || f[wi] > m_best) begin
         m_best = f[wi]; m_keep = 4'(1 << wi); m_first = 0;
      end else begin
         m_keep = 0;
      end
      beats = 0; k = 0;
      while (beats < OFF && k < 300) begin
         e_fd = 0; e_cs = 0; e_ov = 1; e_idx = 8'(beats);
         e_best = m_best; e_keep = m_keep;
         off_ready = (rmode == 0) || (k % 3 == 0);
         if (k == rst_at) begin
            chk = 0;
            RESET_n = 0;
            #1;
            check("rst_off_valid", 16'(off_valid), 16'h0);
            check("rst_gen_count", gen_count, 16'h0);
            check("rst_dp_reset", 16'(dp_reset), 16'h1);
            check("rst_busy", 16'(busy), 16'h0);
            check("rst_off_index", 16'(off_index), 16'h0);
            m_gc = 0; m_best = 0; m_keep = 0; m_first = 1;
            idle_exp();
            off_ready = 1;
            #1;
            RESET_n = 1;
            chk = 1;
            return;
         end
         if (off_ready) beats++;
         k++;
         cyc();
      end
      if (beats < OFF) begin
         n_chk++; n_fail++;
         $display("FAIL offload_timeout: got %0d beats expected %0d", beats, OFF);
      end
      m_gc = (m_gc == 16'hFFFF) ? m_gc : m_gc + 16'd1;
      e_ov = 0; e_gc = m_gc; e_dp = 1;
      e_busy = !(m_lim != 0 && m_gc == m_lim);
      if (!e_busy) idle_exp();
      off_ready = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, f0c, d0c, x0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_dp_reset", 16'(dp_reset), 16'h1);
      check("reset_busy", 16'(busy), 16'h0);
      check("reset_off_valid", 16'(off_valid), 16'h0);
      check("reset_keep_mut", 16'(keep_mut), 16'h0);
      check("reset_gen_count", gen_count, 16'h0);
      RESET_n = 1;
      m_gc = 0; m_best = 0; m_keep = 0; m_first = 1; m_lim = 0;
      idle_exp();
      chk = 1;
      cyc();

      // Single generation, constant ready.
      b0 = busy_cnt; f0c = fa_cnt; d0c = fd_cnt; x0 = xfer_cnt;
      do_start(1);
      gen(10, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 0, -1, -1);
      cyc(); cyc();
      check("t1_busy_cycles", 16'(busy_cnt - b0), 16'd34);
      check("t1_frame_cycles", 16'(fa_cnt - f0c), 16'd10);
      check("t1_frame_done", 16'(fd_cnt - d0c), 16'd1);
      check("t1_transfers", 16'(xfer_cnt - x0), 16'd11);
      check("t1_gen_count", gen_count, 16'd1);
      check("t1_keep", 16'(keep_mut), 16'h0001);

      // Winner selection with a tie, then a non-improving generation.
      do_start(2);
      gen(3, 16'h0102, 16'h0305, 16'h0305, 16'h0001, 0, -1, -1);
      check("t2_keep", 16'(keep_mut), 16'h0002);
      check("t2_best", best_fit, 16'h0305);
      gen(3, 16'h0304, 16'h0304, 16'h0304, 16'h0304, 0, -1, -1);
      cyc();
      check("t2b_keep", 16'(keep_mut), 16'h0000);
      check("t2b_best", best_fit, 16'h0305);
      check("t2b_gen_count", gen_count, 16'd2);

      // Backpressure on the offload stream.
      x0 = xfer_cnt;
      do_start(1);
      gen(4, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1, -1, -1);
      cyc();
      check("t3_transfers", 16'(xfer_cnt - x0), 16'd11);
      check("t3_keep", 16'(keep_mut), 16'h0008);

      // Zero frame duration gives one RUN cycle.
      f0c = fa_cnt;
      do_start(1);
      gen(0, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 0, -1, -1);
      cyc();
      check("t4_frame_cycles", 16'(fa_cnt - f0c), 16'd1);

      // Unlimited run, then abort in RUN cycle 4.
      do_start(0);
      for (int g = 0; g < 5; g++)
         gen(2, 16'(g), 16'(16'h0100 + g), 16'h0050, 16'(g * 3), 0, -1, -1);
      check("t5_gen_count", gen_count, 16'd5);
      check("t5_busy", 16'(busy), 16'h1);
      check("t5_best", best_fit, 16'h0104);
      gen(8, 16'h9999, 16'h1, 16'h1, 16'h1, 0, 3, -1);
      check("t6_dp_reset", 16'(dp_reset), 16'h1);
      check("t6_busy", 16'(busy), 16'h0);
      check("t6_gen_count", gen_count, 16'd5);
      cyc(); cyc();

      // Asynchronous reset in the middle of offload.
      do_start(0);
      gen(2, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, -1, 3);
      cyc(); cyc();
      check("t7_busy", 16'(busy), 16'h0);

      chk = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hhmm_generation_ctrl.md
# hhmm_generation_ctrl

Generation sequencer for the HHMM stochastic network's evolutionary training loop. For each generation it runs these phases in order:
- holds the network datapath in reset;
- runs one evaluation frame of programmable length;
- scans the per-candidate fitness exponents and selects the mutation candidate to keep;
- streams the offload index sequence to the mutation-vector/personal-best offload path under a valid/ready handshake.

It replaces the fixed-count reset/index sequencing done by the host-side PIO logic and sits between the host registers and the candidate datapath.

## Interface
- NC, 4: number of mutation candidates (≥2)
- INIT_CYCLES, 5: datapath-reset cycles before every frame (≥1)
- OFFLOAD_LEN, 11: offload beats per generation (indices 0..OFFLOAD_LEN-1, ≤256)
- CLK  in  1  system clock, all logic on rising edge
- RESET_n  in  1  reset, asynchronous and active-low
- start  in  1  begin a run; sampled in IDLE only
- abort  in  1  return to IDLE; highest priority outside reset
- frame_duration  in  16  frame length in cycles; latched on INIT→RUN; 0 is treated as 1
- gen_limit  in  16  generations per run, latched on start; 0 = unlimited
- fit_upper  in  8  fitness upper exponent of the selected candidate
- fit_lower  in  8  fitness lower exponent of the selected candidate
- off_ready  in  1  offload sink accepts the current beat
- dp_reset  out  1  datapath reset, active-high
- frame_active  out  1  high during every RUN cycle
- frame_done  out  1  one-cycle pulse on the first EVAL cycle
- cand_sel  out  log2(NC) (min 1)  candidate whose fitness is presented
- keep_mut  out  NC  one-hot keep mask of the winning candidate, else all-zero
- best_fit  out  16  global best {upper,lower}
- off_valid  out  1  offload beat valid
- off_index  out  8  offload beat index
- gen_count  out  16  generations completed in this run
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, INIT, RUN, EVAL, OFFLOAD.
- IDLE:
  - dp_reset=1; all other outputs hold their values.
  - When start=1, latch gen_limit, clear gen_count, best_fit and keep_mut, arm the first_gen flag, and go to INIT.
- INIT:
  - dp_reset=1 for exactly INIT_CYCLES cycles, then RUN.
  - frame_duration is latched on that transition.
- RUN:
  - dp_reset=0, frame_active=1 for exactly D cycles (D = latched duration, 0→1), then EVAL.
  - The frame counter is 16-bit; it counts 1..D with no wrap.
- EVAL:
  - For c = 0..NC-1: cand_sel=c for 2 cycles; fitness is sampled on the second cycle.
  - Total EVAL length is 2·NC cycles.
  - Fitness value is F = {fit_upper, fit_lower}, unsigned 16-bit; larger is better.
  - Generation winner: the first index with maximal F, so ties go to the lower index.
- End of EVAL:
  - If first_gen or winner F > best_fit (strictly greater): best_fit←F, keep_mut←one-hot(winner), clear first_gen.
  - Otherwise keep_mut←0 and best_fit is unchanged.
  - Next state is OFFLOAD.
- OFFLOAD:
  - off_valid=1, starting with off_index=0.
  - A beat transfers when off_valid & off_ready; off_index then increments.
  - After the beat with off_index=OFFLOAD_LEN-1 transfers: off_valid=0 and gen_count+1 (saturating at 0xFFFF).
  - If gen_limit≠0 and the new gen_count == gen_limit, go to IDLE; otherwise go to INIT.
  - off_index and off_valid must not change while off_valid=1 & off_ready=0.
- keep_mut and best_fit are registered; they hold from the end of EVAL until the next end of EVAL or the next start.
- abort=1 in any non-IDLE state:
  - next state is IDLE, dp_reset=1, off_valid=0, frame_active=0;
  - gen_count, best_fit and keep_mut are held.
- start is ignored outside IDLE; abort outranks start in IDLE.
- cand_sel=0 outside EVAL.
- Reset values (RESET_n=0): state IDLE, dp_reset=1, every other output 0, first_gen=1.

## Timing
- All outputs are registered.
- State-change effects appear on the cycle after the triggering edge.
- start sampled on edge k → INIT (dp_reset=1, busy=1) from cycle k+1.
- RUN begins at k+1+INIT_CYCLES and lasts D cycles.
- EVAL begins the cycle after the last RUN cycle; frame_done pulses on that cycle only.
- keep_mut/best_fit update and off_valid rises on the cycle after the last EVAL cycle.
- Offload throughput is one beat per cycle when off_ready is held at 1.
- Generation length with constant ready = INIT_CYCLES + D + 2·NC + OFFLOAD_LEN cycles.
- The next INIT starts the cycle after the final beat transfers.
- Asynchronous RESET_n assertion mid-run forces reset values immediately; deassertion is sampled synchronously.

## Test plan
- Reset: RESET_n=0 → dp_reset=1, busy=0, off_valid=0, keep_mut=0. Release, then start=1 with D=10, defaults, gen_limit=1, ready=1 → dp_reset=1 for 5 cycles, frame_active for 10, frame_done once, 11 beats with indices 0..10, gen_count=1, then IDLE. Total 5+10+8+11=34 busy cycles.
- Winner selection: fitness per cand_sel = {0x0102, 0x0305, 0x0305, 0x0001} → keep_mut=4'b0010, best_fit=0x0305. Next generation all 0x0304 → keep_mut=0, best_fit stays 0x0305.
- Backpressure: off_ready toggling 1,0,0,1… → off_index and off_valid stable while stalled; exactly 11 transfers; no index skipped or repeated.
- Boundaries: frame_duration=0 → exactly 1 RUN cycle. gen_limit=0 → 5 generations run with no return to IDLE.
- Abort: abort=1 during RUN cycle 4 → IDLE next cycle, dp_reset=1, gen_count unchanged.
- Async reset: RESET_n=0 mid-OFFLOAD → off_valid=0 in the same cycle, gen_count=0.
